// File: rtl/path_addr_gen_if.sv
// rtl/path_addr_gen_if.sv - request and DRAM command bus bundle for path_addr_gen
//
// Purpose: carries the AddrGen request from the backend controller and the
//   per-burst DRAM command/address stream produced for it.
// Signals:
//   Leaf[ORAML-1:0], Read, Header, InValid -> request (master drives)
//   InReady                                 <- request accepted (slave drives)
//   CmdOut, AddrOut[DDRAWidth-1:0], OutValid, PathDone <- burst stream (slave drives)
//   OutReady                                -> downstream accepts (master drives)
// Modports: master = controller/consumer side, slave = address generator side.

interface path_addr_gen_if #(
  parameter int ORAML     = 10,
  parameter int DDRAWidth = 28
);
  logic [ORAML-1:0]     Leaf;
  logic                 Read;
  logic                 Header;
  logic                 InValid;
  logic                 InReady;
  logic                 CmdOut;
  logic [DDRAWidth-1:0] AddrOut;
  logic                 OutValid;
  logic                 OutReady;
  logic                 PathDone;

  modport master (
    output Leaf, Read, Header, InValid, OutReady,
    input  InReady, CmdOut, AddrOut, OutValid, PathDone
  );

  modport slave (
    input  Leaf, Read, Header, InValid, OutReady,
    output InReady, CmdOut, AddrOut, OutValid, PathDone
  );
endinterface

// File: rtl/path_addr_gen.sv
// rtl/path_addr_gen.sv - ORAM path burst address generator
//
// Purpose: expands one AddrGen request (leaf, read/writeback, header-only)
//   into one DRAM command/address per burst along the tree path to that leaf.
//   Reads walk root to leaf, writebacks walk leaf to root.
// Ports:
//   Clock       clock
//   Reset       synchronous, active-high reset
//   bus         path_addr_gen_if.slave (request in, burst stream out)
//   PathCount   [31:0] completed paths     (only with PATH_ADDR_GEN_STATS_EN)
//   BurstCount  [31:0] accepted bursts     (only with PATH_ADDR_GEN_STATS_EN)
// Optional feature macro: PATH_ADDR_GEN_STATS_EN adds the two statistics counters.

module path_addr_gen #(
  parameter int ORAML             = 10,
  parameter int BktSize_DRBursts  = 3,
  parameter int BktHSize_DRBursts = 1,
  parameter int DDRAWidth         = 28,
  parameter int DDRBstStride      = 8,
  parameter logic [DDRAWidth-1:0] BaseAddr = '0
) (
  input  logic        Clock,
  input  logic        Reset,
  path_addr_gen_if.slave bus
`ifdef PATH_ADDR_GEN_STATS_EN
  ,
  output logic [31:0] PathCount,
  output logic [31:0] BurstCount
`endif
);

  localparam int LW = $clog2(ORAML + 1);
  localparam int BW = $clog2(BktSize_DRBursts + 1);
  // Wide enough for index*bucket*stride plus the base before truncation.
  localparam int CW = ORAML + 2 + $clog2(BktSize_DRBursts + 1)
                    + $clog2(DDRBstStride + 1) + DDRAWidth;

  typedef enum logic {ST_Idle, ST_Issue} state_t;

  state_t               state, stateNext;
  logic [ORAML-1:0]     leafQ;
  logic                 readQ, headerQ, cmdQ;
  logic [LW-1:0]        level, levelNext, levelLast;
  logic [BW-1:0]        burst, burstNext, burstLast;
  logic [DDRAWidth-1:0] addrQ;
  logic                 inReady, outValid, pathDone, accept, xfer;

  assign burstLast = headerQ ? BW'(BktHSize_DRBursts - 1) : BW'(BktSize_DRBursts - 1);
  assign levelLast = readQ ? LW'(ORAML) : '0;

  // Heap-ordered bucket index at level lv, then the burst address inside the
  // full-size bucket slot (header mode still strides by a whole bucket).
  function automatic logic [DDRAWidth-1:0] calcAddr(
    input logic [ORAML-1:0] lf,
    input logic [LW-1:0]    lv,
    input logic [BW-1:0]    bs
  );
    logic [CW-1:0] idx;
    idx = ((CW'(1) << lv) - CW'(1)) + (CW'(lf) >> (CW'(ORAML) - CW'(lv)));
    return DDRAWidth'(CW'(BaseAddr)
                      + (idx * CW'(BktSize_DRBursts) + CW'(bs)) * CW'(DDRBstStride));
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_Idle;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    pathDone  = 1'b0;
    accept    = 1'b0;
    xfer      = 1'b0;
    levelNext = level;
    burstNext = burst;
    case (state)
      ST_Idle: begin
        inReady = 1'b1;
        if (bus.InValid) begin
          accept    = 1'b1;
          stateNext = ST_Issue;
          levelNext = bus.Read ? '0 : LW'(ORAML);
          burstNext = '0;
        end
      end
      ST_Issue: begin
        outValid = 1'b1;
        if (bus.OutReady) begin
          xfer = 1'b1;
          if (burst == burstLast) begin
            burstNext = '0;
            if (level == levelLast) begin
              pathDone  = 1'b1;
              stateNext = ST_Idle;
            end else begin
              levelNext = readQ ? level + LW'(1) : level - LW'(1);
            end
          end else begin
            burstNext = burst + BW'(1);
          end
        end
      end
      default: stateNext = ST_Idle;
    endcase
  end

  // The address register is loaded one step ahead so AddrOut is already
  // valid in the first ST_Issue cycle and holds during stalls.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      leafQ   <= '0;
      readQ   <= 1'b0;
      headerQ <= 1'b0;
      cmdQ    <= 1'b0;
      level   <= '0;
      burst   <= '0;
      addrQ   <= '0;
    end else begin
      level <= levelNext;
      burst <= burstNext;
      if (accept) begin
        leafQ   <= bus.Leaf;
        readQ   <= bus.Read;
        headerQ <= bus.Header;
        cmdQ    <= bus.Read;
        addrQ   <= calcAddr(bus.Leaf, levelNext, '0);
      end else if (xfer && !pathDone) begin
        addrQ <= calcAddr(leafQ, levelNext, burstNext);
      end
    end
  end

  assign bus.InReady  = inReady;
  assign bus.OutValid = outValid;
  assign bus.PathDone = pathDone;
  assign bus.AddrOut  = addrQ;
  assign bus.CmdOut   = cmdQ;

`ifdef PATH_ADDR_GEN_STATS_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      PathCount  <= '0;
      BurstCount <= '0;
    end else begin
      if (pathDone) PathCount  <= PathCount + 32'd1;
      if (xfer)     BurstCount <= BurstCount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/path_addr_gen.md
Name: path_addr_gen

Overview:
- Consumes the backend controller's AddrGen request (leaf, read/write, header-only) and expands it into one DRAM command/address per burst along the ORAM tree path to that leaf.
- Output stream feeds the DRAM command interface; each output handshake is what the controller counts as AddrTransfer.
- Reads walk root→leaf; writebacks walk leaf→root. Header mode emits only each bucket's header bursts.

Parameters:
- ORAML, 10, leaf width; path has ORAML+1 buckets (levels 0..ORAML)
- BktSize_DRBursts, 3, DRAM bursts per full bucket
- BktHSize_DRBursts, 1, DRAM bursts per bucket header (must be ≤ BktSize_DRBursts, ≥1)
- DDRAWidth, 28, DRAM address width
- DDRBstStride, 8, address increment per burst
- BaseAddr, 0, DRAM address of bucket 0 burst 0

Ports:
- Clock  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Leaf  in  ORAML  target leaf; sampled on input handshake
- Read  in  1  1=path read, 0=path writeback; sampled on handshake
- Header  in  1  1=header bursts only; sampled on handshake
- InValid  in  1  request valid
- InReady  out  1  high only in ST_Idle
- CmdOut  out  1  1=DRAM read, 0=DRAM write (=latched Read)
- AddrOut  out  DDRAWidth  DRAM burst address
- OutValid  out  1  address valid
- OutReady  in  1  downstream accepts
- PathDone  out  1  one-cycle pulse, coincident with last burst handshake

Behaviour:
- Interface: one clock, Clock; reset is synchronous and active-high, Reset.
- States: ST_Idle, ST_Issue.
  - ST_Idle: InReady=1. On InValid latch Leaf/Read/Header; set level = Read ? 0 : ORAML; burst=0; go to ST_Issue next cycle.
  - ST_Issue: OutValid=1. Each OutValid&OutReady advances burst.
- Bursts per bucket: BL = Header ? BktHSize_DRBursts : BktSize_DRBursts.
- End of bucket (burst==BL-1 with handshake): burst←0. level←level+1 for a read, level−1 for a writeback.
- Last burst: final bucket is level ORAML for a read, level 0 for a writeback. Its handshake pulses PathDone and returns to ST_Idle. InReady is high the following cycle; there are no back-to-back accepts in the same cycle.
- Bucket index at level l: (2^l − 1) + (Leaf >> (ORAML − l)). Heap order, leaf MSB selects the first branch.
- AddrOut = BaseAddr + (index·BktSize_DRBursts + burst)·DDRBstStride, truncated modulo 2^DDRAWidth. Full bucket stride is used even in header mode.
- Intermediate arithmetic is at least ORAML+1+clog2(BktSize_DRBursts)+clog2(DDRBstStride) bits wide before truncation.
- AddrOut/CmdOut are registered. While OutValid=1 and OutReady=0 they stay stable and state does not advance.
- Total handshakes per request: (ORAML+1)·BL.
- InValid in ST_Issue is ignored; inputs are not re-sampled.
- Reset (any state, including mid-path): ST_Idle, OutValid=0, PathDone=0, InReady=1 next cycle, counters 0, AddrOut=0, CmdOut=0. No partial-path completion pulse.

Optional Feature:
- Macro PATH_ADDR_GEN_STATS_EN.
- Defined: adds outputs PathCount[31:0] and BurstCount[31:0], reset 0.
  - PathCount increments on each PathDone.
  - BurstCount increments on each output handshake.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- ORAML=2, BktSize=2, BktH=1, stride=8, Base=0; read Leaf=2'b10, OutReady=1 → AddrOut 0,8,32,40,80,88, CmdOut=1; PathDone on the 6th handshake; InReady=1 the next cycle.
- Same config, writeback Leaf=2'b10 → 80,88,32,40,0,8, CmdOut=0; header writeback → 80,32,0, PathDone on the 3rd handshake.
- Read Leaf=2'b01 with OutReady toggling 1,0,0,1,… → sequence 0,8,16,24,64,72; AddrOut held constant during stalls; no duplicate or skipped address.
- Default params, Leaf=all-ones, read, Base=2^28−8 → addresses wrap modulo 2^28; exactly 33 handshakes.
- Reset asserted after 3rd handshake of a read → OutValid=0 the next cycle, no PathDone. A new request Leaf=0 then restarts from address Base.
- PATH_ADDR_GEN_STATS_EN: two full reads (default params) → PathCount=2, BurstCount=66.
